// File: rtl/uart_transceiver.sv
`default_nettype none
// ============================================================================
//  Module   : uart_transceiver
//  Purpose  : Independent 8N1 UART transmitter and receiver sharing one clock.
//             Bit timing is a fixed number of clocks per bit. The receiver
//             synchronises its line, rejects short start glitches and
//             discards frames whose stop bit is low.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_transceiver #(
    parameter int TICKS_PER_BIT      = 434,
    parameter int TICKS_PER_BIT_SIZE = 9
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    // transmitter
    input  logic       i_tx_start,
    input  logic [7:0] i_tx_data,
    output logic       o_tx_done,
    output logic       o_tx_busy,
    output logic       o_tx_dout,
    // receiver
    input  logic       i_rx_enable,
    input  logic       i_rx_din,
    output logic [7:0] o_rx_data,
    output logic       o_rx_recv,
    output logic       o_rx_busy
);

    localparam int W = TICKS_PER_BIT_SIZE;

    // Terminal count of a full bit and of the half-bit start qualification.
    localparam logic [W-1:0] c_TICK_LAST = W'(TICKS_PER_BIT - 1);
    localparam logic [W-1:0] c_HALF_LAST = W'((TICKS_PER_BIT / 2) - 1);
    localparam logic [W-1:0] c_TICK_ONE  = W'(1);

    // ------------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------------
    typedef enum logic [2:0] {
        TX_IDLE  = 3'd0,
        TX_START = 3'd1,
        TX_DATA  = 3'd2,
        TX_STOP  = 3'd3,
        TX_DONE  = 3'd4
    } tx_state_e;

    tx_state_e    tx_state_q, tx_state_d;
    logic [W-1:0] tx_cnt_q,   tx_cnt_d;
    logic [2:0]   tx_idx_q,   tx_idx_d;
    logic [7:0]   tx_byte_q,  tx_byte_d;

    // Transmitter state, tick counter, bit index and latched byte.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_idx_q   <= '0;
            tx_byte_q  <= '0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_idx_q   <= tx_idx_d;
            tx_byte_q  <= tx_byte_d;
        end
    end

    // Transmitter next state and Moore outputs; the byte is only captured in
    // IDLE so late changes to i_tx_data cannot corrupt a frame in flight.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_idx_d   = tx_idx_q;
        tx_byte_d  = tx_byte_q;
        o_tx_done  = 1'b0;
        o_tx_busy  = 1'b1;
        o_tx_dout  = 1'b1;

        case (tx_state_q)
            TX_IDLE: begin
                o_tx_busy = 1'b0;
                tx_cnt_d  = '0;
                tx_idx_d  = '0;
                if (i_tx_start) begin
                    tx_byte_d  = i_tx_data;
                    tx_state_d = TX_START;
                end
            end
            TX_START: begin
                o_tx_dout = 1'b0;
                if (tx_cnt_q == c_TICK_LAST) begin
                    tx_cnt_d   = '0;
                    tx_state_d = TX_DATA;
                end else begin
                    tx_cnt_d = tx_cnt_q + c_TICK_ONE;
                end
            end
            TX_DATA: begin
                o_tx_dout = tx_byte_q[tx_idx_q];
                if (tx_cnt_q == c_TICK_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_idx_q == 3'd7) begin
                        tx_idx_d   = '0;
                        tx_state_d = TX_STOP;
                    end else begin
                        tx_idx_d = tx_idx_q + 3'd1;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + c_TICK_ONE;
                end
            end
            TX_STOP: begin
                if (tx_cnt_q == c_TICK_LAST) begin
                    tx_cnt_d   = '0;
                    tx_state_d = TX_DONE;
                end else begin
                    tx_cnt_d = tx_cnt_q + c_TICK_ONE;
                end
            end
            TX_DONE: begin
                o_tx_busy  = 1'b0;
                o_tx_done  = 1'b1;
                tx_state_d = TX_IDLE;
            end
            default: begin
                o_tx_busy  = 1'b0;
                tx_cnt_d   = '0;
                tx_idx_d   = '0;
                tx_state_d = TX_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------------
    typedef enum logic [2:0] {
        RX_IDLE    = 3'd0,
        RX_START   = 3'd1,
        RX_DATA    = 3'd2,
        RX_STOP    = 3'd3,
        RX_CLEANUP = 3'd4
    } rx_state_e;

    logic [1:0]   rx_sync_q;
    logic         rx_s;
    rx_state_e    rx_state_q, rx_state_d;
    logic [W-1:0] rx_cnt_q,   rx_cnt_d;
    logic [2:0]   rx_idx_q,   rx_idx_d;
    logic [7:0]   rx_shift_q, rx_shift_d;
    logic [7:0]   rx_data_q,  rx_data_d;
    logic         rx_recv_q,  rx_recv_d;

    // Two-flop synchroniser; presets to the idle (mark) level.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_sync_q <= 2'b11;
        end else begin
            rx_sync_q <= {rx_sync_q[0], i_rx_din};
        end
    end

    assign rx_s = rx_sync_q[1];

    // Receiver state, counters, shift register and output holding registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_idx_q   <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            rx_recv_q  <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_idx_q   <= rx_idx_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            rx_recv_q  <= rx_recv_d;
        end
    end

    // Receiver next state: qualify the start bit at half a bit, then sample
    // every full bit so each data sample lands near mid-bit.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_idx_d   = rx_idx_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        rx_recv_d  = 1'b0;

        case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                rx_idx_d = '0;
                if (i_rx_enable && !rx_s) begin
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                if (rx_cnt_q == c_HALF_LAST) begin
                    rx_cnt_d = '0;
                    // A line back at mark by mid start bit was only a glitch.
                    rx_state_d = rx_s ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + c_TICK_ONE;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == c_TICK_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_s, rx_shift_q[7:1]};
                    if (rx_idx_q == 3'd7) begin
                        rx_idx_d   = '0;
                        rx_state_d = RX_STOP;
                    end else begin
                        rx_idx_d = rx_idx_q + 3'd1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + c_TICK_ONE;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == c_TICK_LAST) begin
                    rx_cnt_d = '0;
                    // A low stop bit is a framing error: drop the byte.
                    if (rx_s) begin
                        rx_data_d = rx_shift_q;
                        rx_recv_d = 1'b1;
                    end
                    rx_state_d = RX_CLEANUP;
                end else begin
                    rx_cnt_d = rx_cnt_q + c_TICK_ONE;
                end
            end
            RX_CLEANUP: begin
                rx_state_d = RX_IDLE;
            end
            default: begin
                rx_cnt_d   = '0;
                rx_idx_d   = '0;
                rx_state_d = RX_IDLE;
            end
        endcase
    end

    assign o_rx_data = rx_data_q;
    assign o_rx_recv = rx_recv_q;
    assign o_rx_busy = (rx_state_q == RX_DATA) || (rx_state_q == RX_STOP);

endmodule
`default_nettype wire

// File: tb/tb_uart_transceiver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_transceiver
//  Purpose  : Directed self-checking bench for uart_transceiver with four
//             clocks per bit and a 20 ns clock.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_transceiver;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_done, tx_busy, tx_dout;
    logic       rx_en;
    logic       rx_drv;
    logic       loop_sel;
    logic       rx_line;
    logic [7:0] rx_data;
    logic       rx_recv, rx_busy;

    int vecs = 0;
    int errs = 0;
    int done_cnt = 0;
    int recv_cnt = 0;
    int d_done, d_recv;
    logic busy_seen;
    logic [9:0] wf;

    always #10 clk = ~clk;

    assign rx_line = loop_sel ? tx_dout : rx_drv;

    uart_transceiver #(
        .TICKS_PER_BIT      (4),
        .TICKS_PER_BIT_SIZE (3)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_tx_start  (tx_start),
        .i_tx_data   (tx_data),
        .o_tx_done   (tx_done),
        .o_tx_busy   (tx_busy),
        .o_tx_dout   (tx_dout),
        .i_rx_enable (rx_en),
        .i_rx_din    (rx_line),
        .o_rx_data   (rx_data),
        .o_rx_recv   (rx_recv),
        .o_rx_busy   (rx_busy)
    );

    // Pulse counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (tx_done) done_cnt++;
        if (rx_recv) recv_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bit-bang one frame, four clocks per bit; call on a falling edge.
    task automatic rx_frame(input logic [7:0] b, input logic stop_bit);
        logic [9:0] bits;
        bits = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx_drv = bits[i];
            repeat (4) @(negedge clk);
            if (i == 4) busy_seen = rx_busy;
        end
        rx_drv = 1'b1;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; tx_start = 1'b0; tx_data = 8'h00;
        rx_en = 1'b1; rx_drv = 1'b1; loop_sel = 1'b0; busy_seen = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_tx_dout", 32'(tx_dout), 32'h1);
        check("rst_tx_busy", 32'(tx_busy), 32'h0);
        check("rst_tx_done", 32'(tx_done), 32'h0);
        check("rst_rx_data", 32'(rx_data), 32'h00);
        check("rst_rx_recv", 32'(rx_recv), 32'h0);
        check("rst_rx_busy", 32'(rx_busy), 32'h0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Plain receive of 0xAB
        d_recv = recv_cnt;
        rx_frame(8'hAB, 1'b1);
        repeat (6) @(negedge clk);
        check("ab_recv_cnt", 32'(recv_cnt - d_recv), 32'h1);
        check("ab_data", 32'(rx_data), 32'hAB);
        check("ab_busy_after", 32'(rx_busy), 32'h0);
        check("ab_busy_mid", 32'(busy_seen), 32'h1);

        // 40 ns start glitch
        d_recv = recv_cnt;
        rx_drv = 1'b0;
        repeat (2) @(negedge clk);
        rx_drv = 1'b1;
        repeat (10) @(negedge clk);
        check("glitch_recv_cnt", 32'(recv_cnt - d_recv), 32'h0);
        check("glitch_data", 32'(rx_data), 32'hAB);
        check("glitch_busy", 32'(rx_busy), 32'h0);

        // Receiver still healthy after the glitch
        d_recv = recv_cnt;
        rx_frame(8'h96, 1'b1);
        repeat (6) @(negedge clk);
        check("post_glitch_recv_cnt", 32'(recv_cnt - d_recv), 32'h1);
        check("post_glitch_data", 32'(rx_data), 32'h96);

        // Framing error: 0x55 with low stop bit
        d_recv = recv_cnt;
        rx_frame(8'h55, 1'b0);
        repeat (6) @(negedge clk);
        check("frame_err_recv_cnt", 32'(recv_cnt - d_recv), 32'h0);
        check("frame_err_data", 32'(rx_data), 32'h96);

        // Receiver disabled: no frame starts
        rx_en = 1'b0;
        d_recv = recv_cnt;
        rx_frame(8'h5A, 1'b1);
        repeat (6) @(negedge clk);
        check("disabled_recv_cnt", 32'(recv_cnt - d_recv), 32'h0);
        check("disabled_data", 32'(rx_data), 32'h96);
        check("disabled_busy_mid", 32'(busy_seen), 32'h0);

        // Enable dropped mid-frame: the frame in progress completes
        rx_en = 1'b1;
        d_recv = recv_cnt;
        fork
            rx_frame(8'hC3, 1'b1);
            begin
                repeat (10) @(negedge clk);
                rx_en = 1'b0;
            end
        join
        repeat (6) @(negedge clk);
        check("en_drop_recv_cnt", 32'(recv_cnt - d_recv), 32'h1);
        check("en_drop_data", 32'(rx_data), 32'hC3);
        rx_en = 1'b1;

        // Loopback of 0x0D with waveform check at mid-bit
        loop_sel = 1'b1;
        repeat (3) @(negedge clk);
        d_done = done_cnt; d_recv = recv_cnt;
        wf = 10'b10_0001_1010;
        tx_start = 1'b1; tx_data = 8'h0D;
        @(posedge clk);
        #1 tx_start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("lb_busy", 32'(tx_busy), 32'h1);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("lb_bit%0d", i), 32'(tx_dout), 32'(wf[i]));
            repeat (4) @(posedge clk);
            #1;
        end
        repeat (8) @(negedge clk);
        check("lb_done_cnt", 32'(done_cnt - d_done), 32'h1);
        check("lb_recv_cnt", 32'(recv_cnt - d_recv), 32'h1);
        check("lb_rx_data", 32'(rx_data), 32'h0D);
        check("lb_busy_after", 32'(tx_busy), 32'h0);

        // Restart request mid-frame is ignored
        d_done = done_cnt; d_recv = recv_cnt;
        tx_start = 1'b1; tx_data = 8'h3C;
        @(negedge clk);
        tx_start = 1'b0;
        repeat (12) @(negedge clk);
        tx_start = 1'b1; tx_data = 8'hFF;
        @(negedge clk);
        tx_start = 1'b0; tx_data = 8'h00;
        repeat (40) @(negedge clk);
        check("restart_done_cnt", 32'(done_cnt - d_done), 32'h1);
        check("restart_recv_cnt", 32'(recv_cnt - d_recv), 32'h1);
        check("restart_rx_data", 32'(rx_data), 32'h3C);
        check("restart_busy_after", 32'(tx_busy), 32'h0);

        // Reset during TX DATA aborts the frame
        d_done = done_cnt; d_recv = recv_cnt;
        tx_start = 1'b1; tx_data = 8'hA5;
        @(negedge clk);
        tx_start = 1'b0;
        repeat (10) @(negedge clk);
        check("abort_busy_before", 32'(tx_busy), 32'h1);
        rst_n = 1'b0;
        #1;
        check("abort_tx_dout", 32'(tx_dout), 32'h1);
        check("abort_tx_busy", 32'(tx_busy), 32'h0);
        check("abort_rx_data", 32'(rx_data), 32'h00);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (50) @(negedge clk);
        check("abort_done_cnt", 32'(done_cnt - d_done), 32'h0);
        check("abort_recv_cnt", 32'(recv_cnt - d_recv), 32'h0);
        check("abort_busy_after", 32'(tx_busy), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_transceiver.md
UART_TRANSCEIVER -- requirements
Module: uart_transceiver

Interface
REQ-001 SHALL have parameter TICKS_PER_BIT, default 434, giving clock cycles per bit period (50 MHz / 115200 baud); legal range >= 4.
REQ-002 SHALL have parameter TICKS_PER_BIT_SIZE, default 9, giving the bit width of the tick counters; it must hold TICKS_PER_BIT.
REQ-003 SHALL have one clock and an asynchronous, active-low reset.
REQ-004 i_clk  input  1  system clock; all logic on rising edge.
REQ-005 i_rst_n  input  1  asynchronous active-low reset.
REQ-006 i_tx_start  input  1  request to transmit i_tx_data; sampled each clock.
REQ-007 i_tx_data  input  8  byte to transmit; latched when a start is accepted.
REQ-008 o_tx_done  output  1  one-cycle pulse after the stop bit completes.
REQ-009 o_tx_busy  output  1  high while a frame is being transmitted.
REQ-010 o_tx_dout  output  1  serial TX line; idles high.
REQ-011 i_rx_enable  input  1  receiver enable.
REQ-012 i_rx_din  input  1  serial RX line; asynchronous to i_clk.
REQ-013 o_rx_data  output  8  last correctly received byte; held until the next valid frame.
REQ-014 o_rx_recv  output  1  one-cycle pulse when o_rx_data is updated.
REQ-015 o_rx_busy  output  1  high while the receiver is inside a frame.

Function
REQ-016 Frame format SHALL be 8N1: start bit 0, 8 data bits LSB first, stop bit 1; each bit lasts exactly TICKS_PER_BIT clocks.
REQ-017 TX FSM states SHALL be IDLE, START, DATA, STOP, DONE.
REQ-018 TX IDLE: o_tx_dout=1, o_tx_busy=0; on i_tx_start=1, latch i_tx_data and enter START on the next clock.
REQ-019 TX START/DATA/STOP: o_tx_busy=1; o_tx_dout drives the current bit for TICKS_PER_BIT clocks, then advances; DATA uses a 3-bit index and advances bit 0..7.
REQ-020 TX DONE: o_tx_done=1 for exactly one clock, o_tx_dout=1, o_tx_busy=0; return to IDLE; back-to-back starts are accepted from the next IDLE cycle.
REQ-021 i_tx_start asserted while not IDLE SHALL be ignored; a change to i_tx_data during a frame SHALL NOT alter the frame.
REQ-022 i_rx_din SHALL pass through a 2-flop synchronizer; all RX decisions use the synchronized value.
REQ-023 RX FSM states SHALL be IDLE, START, DATA, STOP, CLEANUP.
REQ-024 RX IDLE: o_rx_busy=0; when i_rx_enable=1 and synchronized input=0, enter START.
REQ-025 RX START: after TICKS_PER_BIT/2 clocks (integer division), resample; if 0, reset the counter and enter DATA with o_rx_busy=1; if 1, treat as a glitch and return to IDLE with no output change.
REQ-026 RX DATA: sample one bit every TICKS_PER_BIT clocks (mid-bit), shifting LSB first into an internal register; after bit 7, enter STOP.
REQ-027 RX STOP: after TICKS_PER_BIT clocks, sample; if 1, load o_rx_data from the shift register and pulse o_rx_recv for one clock; if 0 (framing error), discard the byte and leave o_rx_data unchanged; then enter CLEANUP.
REQ-028 RX CLEANUP: lasts one clock, o_rx_busy=0, then IDLE; the next start edge is detected only after this.
REQ-029 i_rx_enable=0 SHALL prevent a new frame from starting only; a frame already in progress SHALL complete.
REQ-030 TX and RX SHALL be fully independent; external loopback (o_tx_dout to i_rx_din) SHALL work.
REQ-031 Tick counters SHALL count 0..TICKS_PER_BIT-1 and SHALL NOT wrap past the terminal count.

Reset
REQ-032 While i_rst_n=0, regardless of clock: both FSMs IDLE, counters 0, o_tx_dout=1, o_tx_busy=0, o_tx_done=0, o_rx_data=8'h00, o_rx_recv=0, o_rx_busy=0, synchronizer flops=1.
REQ-033 Reset asserted mid-frame SHALL abort the frame immediately with no done/recv pulse; operation resumes on the first clock after release.

Verification (TICKS_PER_BIT=4, 20 ns clock)
REQ-034 Bit-banged 0xAB at 80 ns/bit into i_rx_din, enable=1 -> one o_rx_recv pulse, o_rx_data=0xAB, o_rx_busy low afterwards.
REQ-035 Loopback, i_tx_start pulse with 0x0D -> o_tx_dout waveform 0,1,0,1,1,0,0,0,0,1; one o_tx_done pulse; o_rx_data=0x0D.
REQ-036 40 ns low glitch on idle i_rx_din -> no o_rx_recv, o_rx_data unchanged, receiver back in IDLE.
REQ-037 Frame 0x55 with stop bit 0 -> no o_rx_recv; o_rx_data keeps its previous value.
REQ-038 i_tx_start re-pulsed mid-frame with new data -> ignored; exactly one frame and one o_tx_done.
REQ-039 i_rst_n pulsed low during TX DATA -> o_tx_dout=1 and o_tx_busy=0 immediately; no o_tx_done.
